// File: rtl/queue_op_engine.sv
// Bounded deque executing queue-method commands one at a time.
// Storage is a circular buffer addressed as (head + logical index) mod DEPTH.
// INSERT and DELETE_IDX move one entry per cycle through the SHIFT states.
module queue_op_engine #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [2:0]               i_cmd_op,
  input  logic signed [IDX_W-1:0]  i_cmd_index,
  input  logic [DATA_W-1:0]        i_cmd_data,
  output logic                     o_rsp_valid,
  output logic [DATA_W-1:0]        o_rsp_data,
  output logic                     o_rsp_err,
  output logic [$clog2(DEPTH):0]   o_q_size,
  output logic                     o_q_empty,
  output logic                     o_q_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;

  localparam logic [2:0] OP_NOP = 3'd0, OP_PUSH_F = 3'd1, OP_PUSH_B = 3'd2,
                         OP_POP_F = 3'd3, OP_POP_B = 3'd4, OP_INSERT = 3'd5,
                         OP_DEL_IDX = 3'd6, OP_DEL_ALL = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT_INS, S_SHIFT_DEL} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_head;
  logic [SW-1:0]     r_size;
  logic [AW-1:0]     r_pos;   // logical entry being moved this cycle
  logic [AW-1:0]     r_idx;   // target index of the pending insert
  logic [DATA_W-1:0] r_data;  // value to land at r_idx once the gap is open
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_full, w_empty, w_idx_neg, w_ins_ok, w_del_ok;
  logic [IDX_W-1:0]  w_idx_u, w_size_x;
  logic [AW-1:0]     w_idx, w_tail, w_last, w_pa, w_pb, w_head_m1;

  // Command decode helpers and physical addresses for the current state
  always_comb begin
    w_full    = (r_size == SW'(DEPTH));
    w_empty   = (r_size == '0);
    w_idx_neg = i_cmd_index[IDX_W-1];
    w_idx_u   = i_cmd_index;
    w_size_x  = IDX_W'(r_size);
    // Append at idx==size is legal; a full queue rejects every insert
    w_ins_ok  = !w_idx_neg && (w_idx_u <= w_size_x) && !w_full;
    w_del_ok  = !w_idx_neg && (w_idx_u < w_size_x);
    w_idx     = i_cmd_index[AW-1:0];
    w_tail    = r_head + r_size[AW-1:0];
    w_last    = r_head + r_size[AW-1:0] - AW'(1);
    w_head_m1 = r_head - AW'(1);
    w_pa      = r_head + r_pos;
    w_pb      = r_head + r_pos + AW'(1);
  end

  // Main FSM: command execution, storage writes and registered responses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_size      <= '0;
      r_pos       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (i_cmd_valid) begin
          // NOP is accepted silently; everything else answers
          r_rsp_valid <= (i_cmd_op != OP_NOP);
          case (i_cmd_op)
            OP_PUSH_F: if (w_full) r_rsp_err <= 1'b1;
              else begin
                r_head           <= w_head_m1;
                r_mem[w_head_m1] <= i_cmd_data;
                r_size           <= r_size + SW'(1);
              end
            OP_PUSH_B: if (w_full) r_rsp_err <= 1'b1;
              else begin
                r_mem[w_tail] <= i_cmd_data;
                r_size        <= r_size + SW'(1);
              end
            OP_POP_F: if (w_empty) r_rsp_err <= 1'b1;
              else begin
                r_rsp_data <= r_mem[r_head];
                r_head     <= r_head + AW'(1);
                r_size     <= r_size - SW'(1);
              end
            OP_POP_B: if (w_empty) r_rsp_err <= 1'b1;
              else begin
                r_rsp_data <= r_mem[w_last];
                r_size     <= r_size - SW'(1);
              end
            OP_INSERT: if (!w_ins_ok) r_rsp_err <= 1'b1;
              else if (SW'(w_idx) == r_size) begin
                r_mem[w_tail] <= i_cmd_data;
                r_size        <= r_size + SW'(1);
              end else begin
                // Response deferred until the last shift lands
                r_rsp_valid <= 1'b0;
                r_state     <= S_SHIFT_INS;
                r_pos       <= r_size[AW-1:0] - AW'(1);
                r_idx       <= w_idx;
                r_data      <= i_cmd_data;
              end
            OP_DEL_IDX: if (!w_del_ok) r_rsp_err <= 1'b1;
              else if (SW'(w_idx) + SW'(1) == r_size) begin
                r_size <= r_size - SW'(1);
              end else begin
                r_rsp_valid <= 1'b0;
                r_state     <= S_SHIFT_DEL;
                r_pos       <= w_idx;
              end
            OP_DEL_ALL: r_size <= '0;
            default: ;
          endcase
        end
        S_SHIFT_INS: begin
          // Move entry pos up to pos+1, highest first; at idx also drop in the new value
          r_mem[w_pb] <= r_mem[w_pa];
          if (r_pos == r_idx) begin
            r_mem[w_pa] <= r_data;
            r_size      <= r_size + SW'(1);
            r_rsp_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_pos <= r_pos - AW'(1);
          end
        end
        S_SHIFT_DEL: begin
          // Move entry pos+1 down to pos, lowest first; stop after the tail moves
          r_mem[w_pa] <= r_mem[w_pb];
          if (SW'(r_pos) + SW'(2) == r_size) begin
            r_size      <= r_size - SW'(1);
            r_rsp_valid <= 1'b1;
            r_state     <= S_IDLE;
          end else begin
            r_pos <= r_pos + AW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == S_IDLE);
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_q_size    = r_size;
  assign o_q_empty   = w_empty;
  assign o_q_full    = w_full;
endmodule
